adc_spi_resp: RTL and testbench

- Synthesizable SPI responder modelling the 8-channel 12-bit A2D converter at the far end of the A2D interface.
- Receives 16-bit command frames on MOSI and extracts the 3-bit channel field.
- On MISO, returns the conversion result of the channel addressed in the previous frame.
- Used as the converter model in top-level and slide-pot benches, and as an FPGA stand-in when pot values come from registers.

---
 rtl/a2d_pkg.sv | 16 +
 rtl/adc_spi_resp_sync2.sv | 25 ++
 rtl/adc_spi_resp.sv | 144 ++++++++++++++
 tb/tb_adc_spi_resp.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/a2d_pkg.sv
// Shared types and constants for the A2D converter SPI responder.
// Frame length, channel field position, result width and FSM states.
package a2d_pkg;

  localparam int FRAME_BITS = 16;
  localparam int CH_LSB     = 11;

  typedef logic [11:0] result_t;

  typedef enum logic [1:0] {
    WAIT_HI,
    IDLE,
    ACTIVE
  } state_t;

endpackage

// File: rtl/adc_spi_resp_sync2.sv
// Two-flop synchronizer for one asynchronous input bit.
// RST_VAL sets the value both flops take during reset.
module sync2 #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // Two-stage capture into the clk domain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/adc_spi_resp.sv
// SPI mode-0 responder modelling an 8-channel 12-bit A2D converter.
// Returns the result for the channel addressed in the previous frame.
module adc_spi_resp
  import a2d_pkg::*;
#(
  parameter int FRAME_BITS = a2d_pkg::FRAME_BITS,
  parameter int CH_LSB     = a2d_pkg::CH_LSB
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             SS_n,
  input  logic             SCLK,
  input  logic             MOSI,
  input  logic [7:0][11:0] ch_val,
  output logic             MISO,
  output logic             cmd_valid,
  output logic [2:0]       cmd_chnnl,
  output logic             frame_err
);

  localparam int CW = $clog2(FRAME_BITS + 2);
  localparam logic [CW-1:0] CNT_MAX = CW'(FRAME_BITS + 1);
  localparam logic [CW-1:0] CNT_OK  = CW'(FRAME_BITS);

  logic ss_s, sclk_s, mosi_s;
  logic ss_q, sclk_q;
  logic ss_fall, ss_rise, sclk_fall, sclk_rise;
  logic [1:0] rdy;

  state_t state_q, state_d;
  logic start, done, ok;

  logic [15:0]   tx_shft, rx_shft, rx_nxt;
  logic [CW-1:0] bit_cnt, cnt_nxt;
  logic [2:0]    prev_chnnl;
  result_t       sel_val;

  sync2 #(.RST_VAL(1'b1)) u_ss (
    .clk(clk), .rst_n(rst_n), .d(SS_n), .q(ss_s)
  );
  sync2 #(.RST_VAL(1'b1)) u_sclk (
    .clk(clk), .rst_n(rst_n), .d(SCLK), .q(sclk_s)
  );
  sync2 #(.RST_VAL(1'b0)) u_mosi (
    .clk(clk), .rst_n(rst_n), .d(MOSI), .q(mosi_s)
  );

  assign ss_fall   = ss_q & ~ss_s;
  assign ss_rise   = ~ss_q & ss_s;
  assign sclk_fall = sclk_q & ~sclk_s;
  assign sclk_rise = ~sclk_q & sclk_s;
  assign sel_val   = ch_val[prev_chnnl];
  assign MISO      = (state_q == ACTIVE) ? tx_shft[15] : 1'b0;

  // Edge-detect flops, plus a settle delay that hides reset-value
  // synchronizer contents from WAIT_HI until real input has arrived
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ss_q   <= 1'b1;
      sclk_q <= 1'b1;
      rdy    <= 2'b00;
    end else begin
      ss_q   <= ss_s;
      sclk_q <= sclk_s;
      rdy    <= {rdy[0], 1'b1};
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= WAIT_HI;
    else        state_q <= state_d;
  end

  // Next state and frame start/end strobes
  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      WAIT_HI: if (rdy[1] && ss_s && ss_q) state_d = IDLE;
      IDLE: begin
        if (ss_fall) begin
          start   = 1'b1;
          state_d = ACTIVE;
        end
      end
      ACTIVE: begin
        if (ss_rise) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = WAIT_HI;
    endcase
  end

  // Receive shift and bit count, computed ahead so a same-clk
  // SS_n rise resolves the frame including the last SCLK edge
  always_comb begin
    rx_nxt  = rx_shft;
    cnt_nxt = bit_cnt;
    if (state_q == ACTIVE && sclk_rise) begin
      rx_nxt = {rx_shft[14:0], mosi_s};
      if (bit_cnt != CNT_MAX) cnt_nxt = bit_cnt + 1'b1;
    end
  end

  assign ok = (cnt_nxt == CNT_OK);

  // Shift registers, counter and frame resolution
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_shft    <= '0;
      rx_shft    <= '0;
      bit_cnt    <= '0;
      prev_chnnl <= '0;
      cmd_chnnl  <= '0;
      cmd_valid  <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      cmd_valid <= 1'b0;
      frame_err <= 1'b0;
      rx_shft   <= rx_nxt;
      bit_cnt   <= cnt_nxt;
      if (start) begin
        tx_shft <= {4'h0, sel_val};
        bit_cnt <= '0;
      end else if (state_q == ACTIVE && sclk_fall && bit_cnt != '0) begin
        tx_shft <= {tx_shft[14:0], 1'b0};
      end
      if (done) begin
        if (ok) begin
          cmd_chnnl  <= rx_nxt[CH_LSB+2:CH_LSB];
          prev_chnnl <= rx_nxt[CH_LSB+2:CH_LSB];
          cmd_valid  <= 1'b1;
        end else begin
          frame_err  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_adc_spi_resp.sv
// Directed bench for adc_spi_resp: SPI frames driven by hand,
// returned MISO words and pulse counts checked against constants.
module tb_adc_spi_resp;
  import a2d_pkg::*;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             SS_n;
  logic             SCLK;
  logic             MOSI;
  logic [7:0][11:0] ch_val;
  logic             MISO;
  logic             cmd_valid;
  logic [2:0]       cmd_chnnl;
  logic             frame_err;

  int ncmp = 0;
  int nbad = 0;
  int cv_n = 0;
  int fe_n = 0;
  int cv0, fe0;
  logic [15:0] rx;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (cmd_valid) cv_n <= cv_n + 1;
    if (frame_err) fe_n <= fe_n + 1;
  end

  adc_spi_resp dut (
    .clk(clk),
    .rst_n(rst_n),
    .SS_n(SS_n),
    .SCLK(SCLK),
    .MOSI(MOSI),
    .ch_val(ch_val),
    .MISO(MISO),
    .cmd_valid(cmd_valid),
    .cmd_chnnl(cmd_chnnl),
    .frame_err(frame_err)
  );

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nbad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic sclk_bit(input logic b, output logic m);
    SCLK = 1'b0;
    MOSI = b;
    clks(10);
    m = MISO;
    SCLK = 1'b1;
    clks(10);
  endtask

  task automatic frame(input logic [15:0] cmd, input int n,
                       input int chg, output logic [15:0] got);
    logic m, b;
    got = '0;
    SS_n = 1'b0;
    clks(10);
    for (int i = 0; i < n; i++) begin
      if (i == chg) ch_val[7] = 12'hFFF;
      b = (i < 16) ? cmd[15 - (i % 16)] : 1'b0;
      sclk_bit(b, m);
      if (i < 16) got[15 - i] = m;
    end
    clks(10);
    SS_n = 1'b1;
    clks(12);
  endtask

  initial begin
    logic m;
    rst_n = 1'b0;
    SS_n = 1'b0;
    SCLK = 1'b1;
    MOSI = 1'b0;
    ch_val = '0;
    clks(3);
    check("rst_miso", 32'(MISO), 0);
    check("rst_cv", 32'(cmd_valid), 0);
    check("rst_fe", 32'(frame_err), 0);
    check("rst_chnnl", 32'(cmd_chnnl), 0);

    rst_n = 1'b1;
    clks(3);
    for (int i = 0; i < 4; i++) begin
      SCLK = 1'b0; clks(10);
      SCLK = 1'b1; clks(10);
    end
    check("lowss_state", 32'(dut.state_q), 32'(WAIT_HI));
    check("lowss_miso", 32'(MISO), 0);
    SS_n = 1'b1;
    clks(12);
    check("lowss_idle", 32'(dut.state_q), 32'(IDLE));
    check("lowss_cv", 32'(cv_n), 0);
    check("lowss_fe", 32'(fe_n), 0);

    ch_val[0] = 12'hABC;
    ch_val[3] = 12'h123;
    ch_val[5] = 12'h5A5;
    ch_val[6] = 12'h666;
    ch_val[7] = 12'h456;

    cv0 = cv_n; fe0 = fe_n;
    frame(16'h1800, 16, -1, rx);
    check("f1_miso", 32'(rx), 32'h0ABC);
    check("f1_cv", 32'(cv_n - cv0), 1);
    check("f1_fe", 32'(fe_n - fe0), 0);
    check("f1_chnnl", 32'(cmd_chnnl), 3);

    cv0 = cv_n; fe0 = fe_n;
    frame(16'h2800, 16, -1, rx);
    check("f2_miso", 32'(rx), 32'h0123);
    check("f2_cv", 32'(cv_n - cv0), 1);
    check("f2_chnnl", 32'(cmd_chnnl), 5);

    cv0 = cv_n; fe0 = fe_n;
    frame(16'h1000, 15, -1, rx);
    check("f15_fe", 32'(fe_n - fe0), 1);
    check("f15_cv", 32'(cv_n - cv0), 0);
    check("f15_chnnl", 32'(cmd_chnnl), 5);

    cv0 = cv_n; fe0 = fe_n;
    frame(16'h1000, 17, -1, rx);
    check("f17_fe", 32'(fe_n - fe0), 1);
    check("f17_cv", 32'(cv_n - cv0), 0);
    check("f17_chnnl", 32'(cmd_chnnl), 5);

    cv0 = cv_n; fe0 = fe_n;
    frame(16'h3000, 16, -1, rx);
    check("aft_err_miso", 32'(rx), 32'h05A5);
    check("aft_err_chnnl", 32'(cmd_chnnl), 6);

    cv0 = cv_n; fe0 = fe_n;
    SS_n = 1'b0;
    clks(10);
    for (int i = 0; i < 8; i++) sclk_bit(1'b1, m);
    rst_n = 1'b0;
    clks(2);
    check("midrst_miso", 32'(MISO), 0);
    check("midrst_chnnl", 32'(cmd_chnnl), 0);
    check("midrst_cv", 32'(cmd_valid), 0);
    check("midrst_fe", 32'(frame_err), 0);
    clks(2);
    rst_n = 1'b1;
    clks(10);
    SS_n = 1'b1;
    clks(12);
    check("midrst_cvn", 32'(cv_n - cv0), 0);
    check("midrst_fen", 32'(fe_n - fe0), 0);

    cv0 = cv_n; fe0 = fe_n;
    frame(16'h3800, 16, -1, rx);
    check("postrst_miso", 32'(rx), 32'h0ABC);
    check("postrst_cv", 32'(cv_n - cv0), 1);
    check("postrst_chnnl", 32'(cmd_chnnl), 7);

    frame(16'h3800, 16, 8, rx);
    check("chg_cur_miso", 32'(rx), 32'h0456);

    frame(16'h0000, 16, -1, rx);
    check("chg_next_miso", 32'(rx), 32'h0FFF);
    check("chg_next_chnnl", 32'(cmd_chnnl), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
    $finish;
  end

endmodule
